// File: rtl/demux64x1_8_wr_if.sv
// Write-request channel for demux64x1_8_wr: valid/ready handshake carrying
// a destination index and a data word.
interface demux64x1_8_wr_if #(
    parameter int WIDTH = 64
);
    logic             wr_valid;
    logic             wr_ready;
    logic [2:0]       wr_sel;
    logic [WIDTH-1:0] wr_data;

    modport master (output wr_valid, output wr_sel, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_sel, input wr_data, output wr_ready);
endinterface

// File: rtl/demux64x1_8_wr.sv
// Registered 1-to-8 write distributor: capture stage, then commit into one of eight holding registers.
// Optional macro DEMUX_ZERO_REG_EN turns entry 7 into a hardwired zero register.
module demux64x1_8_wr #(
    parameter int               WIDTH     = 64,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic               clk,
    input  logic               reset_n,
    demux64x1_8_wr_if.slave    wr,
    input  logic               stall,
    input  logic [7:0]         clr,
    output logic [WIDTH-1:0]   out0,
    output logic [WIDTH-1:0]   out1,
    output logic [WIDTH-1:0]   out2,
    output logic [WIDTH-1:0]   out3,
    output logic [WIDTH-1:0]   out4,
    output logic [WIDTH-1:0]   out5,
    output logic [WIDTH-1:0]   out6,
    output logic [WIDTH-1:0]   out7,
    output logic [7:0]         written,
    output logic               wr_ack,
    output logic [2:0]         ack_sel
);

    logic             s1_valid_q, s1_valid_d;
    logic [2:0]       s1_sel_q,   s1_sel_d;
    logic [WIDTH-1:0] s1_data_q,  s1_data_d;
    logic [WIDTH-1:0] out_q [8];
    logic [WIDTH-1:0] out_d [8];
    logic [7:0]       written_q,  written_d;
    logic             wr_ack_q,   wr_ack_d;
    logic [2:0]       ack_sel_q,  ack_sel_d;

    logic             commit;
    logic             handshake;
    logic [7:0]       entry_we;

    assign commit      = s1_valid_q && !stall;
    assign wr.wr_ready = !s1_valid_q || !stall;
    assign handshake   = wr.wr_valid && wr.wr_ready;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_dec
            assign entry_we[gi] = commit && (s1_sel_q == 3'(gi));
        end
    endgenerate

    // A new capture takes priority over draining, so back-to-back requests stream at one per cycle.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sel_d   = s1_sel_q;
        s1_data_d  = s1_data_q;
        if (handshake) begin
            s1_valid_d = 1'b1;
            s1_sel_d   = wr.wr_sel;
            s1_data_d  = wr.wr_data;
        end else if (commit) begin
            s1_valid_d = 1'b0;
        end
    end

    // Commit sets the flag after clearing so a same-edge write beats clr.
    always_comb begin
        written_d = written_q & ~clr;
        for (int i = 0; i < 8; i++) begin
            out_d[i] = out_q[i];
            if (entry_we[i]) begin
                out_d[i]     = s1_data_q;
                written_d[i] = 1'b1;
            end
        end
`ifdef DEMUX_ZERO_REG_EN
        out_d[7]     = '0;
        written_d[7] = 1'b0;
`endif
    end

    always_comb begin
        wr_ack_d  = commit;
        ack_sel_d = commit ? s1_sel_q : ack_sel_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_sel_q   <= 3'd0;
            s1_data_q  <= '0;
            for (int i = 0; i < 8; i++) begin
                out_q[i] <= RESET_VAL;
            end
`ifdef DEMUX_ZERO_REG_EN
            out_q[7]   <= '0;
`endif
            written_q  <= 8'h00;
            wr_ack_q   <= 1'b0;
            ack_sel_q  <= 3'd0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_sel_q   <= s1_sel_d;
            s1_data_q  <= s1_data_d;
            for (int i = 0; i < 8; i++) begin
                out_q[i] <= out_d[i];
            end
            written_q  <= written_d;
            wr_ack_q   <= wr_ack_d;
            ack_sel_q  <= ack_sel_d;
        end
    end

    assign out0    = out_q[0];
    assign out1    = out_q[1];
    assign out2    = out_q[2];
    assign out3    = out_q[3];
    assign out4    = out_q[4];
    assign out5    = out_q[5];
    assign out6    = out_q[6];
    assign out7    = out_q[7];
    assign written = written_q;
    assign wr_ack  = wr_ack_q;
    assign ack_sel = ack_sel_q;

endmodule

// File: doc/demux64x1_8_wr.md
Name: demux64x1_8_wr

Overview:
- Registered 64-bit 1-to-8 write distributor: the write-side counterpart of the 64-bit 8-to-1 read select.
- Accepts one {sel, data} write request per cycle on a valid/ready handshake and commits it into one of eight 64-bit holding registers.
- Holding registers drive out0..out7 continuously.
- Used ahead of register-bank and forwarding logic, where the pipeline deposits a result into one of eight destinations.

Parameters:
- WIDTH, 64, data width of the request and of each holding register.
- RESET_VAL, 64'h0, value loaded into every holding register on reset.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- wr_valid  input  1  write request present.
- wr_ready  output  1  block can accept a request this cycle.
- wr_sel  input  3  destination index 0..7.
- wr_data  input  WIDTH  write data.
- stall  input  1  holds the commit stage; no commit while high.
- clr  input  8  one-hot-or-multi clear of per-entry written flags.
- out0..out7  output  WIDTH each  holding register contents.
- written  output  8  per-entry "written since reset/clear" flag.
- wr_ack  output  1  one-cycle pulse after each commit.
- ack_sel  output  3  index of the entry committed, valid while wr_ack=1.

Behaviour:
- Reset (reset_n=0, asynchronous, takes effect immediately mid-operation):
  - out0..out7 = RESET_VAL; written = 0; wr_ack = 0; ack_sel = 0.
  - Stage-1 valid = 0; wr_ready = 1 (combinational: no entry is held).
  - Any pending stage-1 request is discarded without a commit.
- Stage 1 (capture register s1_valid/s1_sel/s1_data):
  - wr_ready = !s1_valid || !stall (combinational).
  - A handshake occurs when wr_valid && wr_ready. On that edge s1 loads {1, wr_sel, wr_data}.
  - If there is no handshake and s1 commits, s1_valid clears.
  - If stall=1 and s1_valid=1, s1 holds its value and wr_ready=0.
- Stage 2 (commit):
  - On an edge with s1_valid && !stall, the 3-to-8 decode of s1_sel writes s1_data into out[s1_sel] and sets written[s1_sel].
  - Exactly one entry is written; all others hold.
- Latency:
  - Request accepted at edge N appears on out[sel] after edge N+1 when stall=0.
  - Sustained throughput is 1 write/cycle; back-to-back handshakes with commits at every edge are legal.
- Ack:
  - wr_ack is registered and goes to 1 for exactly the cycle following each commit edge, with ack_sel = the committed index. Otherwise wr_ack = 0.
  - Consecutive commits produce wr_ack held high with ack_sel updating every cycle.
- Clear:
  - clr[i]=1 at an edge clears written[i]; out registers are unaffected.
  - If clr[i] and a commit to entry i occur on the same edge, the commit wins and written[i]=1.
- Same-entry repeats: back-to-back writes to the same index are applied in order; the last one wins.
- stall asserted with s1 empty: wr_ready=1, so one request may be captured and is then held.
- wr_sel values are always 0..7, so every value is legal. X on wr_sel while wr_valid=0 is ignored.

Optional Feature:
- Macro: DEMUX_ZERO_REG_EN.
- Defined:
  - Entry 7 is a hardwired zero register (the ARM XZR convention): out7 is constant 0.
  - Commits to index 7 are accepted, handshaked and acked normally (wr_ack=1, ack_sel=7), but do not change out7 and do not set written[7].
  - written[7] stays 0.
- Not defined: entry 7 behaves identically to entries 0..6.

Test Plan:
- Reset check: hold reset_n=0 and pulse clk -> out0..out7=0, written=8'h00, wr_ready=1, wr_ack=0. Then assert reset_n=0 asynchronously mid-cycle with s1 full -> immediate clear and no later commit.
- Single write: wr_sel=3, wr_data=64'hDEAD_BEEF_0000_0003 for one cycle -> out3 = that value after the second edge; written=8'h08; wr_ack=1 with ack_sel=3 for one cycle; all other outs remain 0.
- Sweep: back-to-back writes of data=i to sel=i for i=0..7 with no stall -> outi=i, written=8'hFF, eight consecutive wr_ack cycles with ack_sel=0..7 (entry 7 only without DEMUX_ZERO_REG_EN).
- Stall: capture sel=5, data=64'h55, then assert stall for 3 cycles -> wr_ready=0 and out5 unchanged during the stall. Release -> out5=64'h55 after the next edge, with one wr_ack.
- Clear vs. write collision: written[2]=1, then clr=8'h04 on the same edge as a commit to sel=2 with data=64'h22 -> written[2]=1, out2=64'h22. Next cycle clr=8'h04 alone -> written[2]=0, out2 stays 64'h22.
- Zero reg (DEMUX_ZERO_REG_EN defined): write sel=7, data=64'hFFFF -> wr_ack=1 with ack_sel=7; out7=0; written[7]=0.
